// File: rtl/demux4_rr_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : demux4_rr_dispatch
// Purpose  : Round-robin dispatcher in front of a 1:4 demux datapath. Takes
//            one word at a time from a valid/ready input stream, holds it, and
//            presents it to the next enabled lane until that lane is ready.
//            Lanes can be masked at run time through lane_en.
// Ports    : clk        rising-edge clock
//            rst        synchronous active-high reset
//            lane_en    [3:0]        lane eligibility mask
//            in_valid   input word valid
//            in_ready   block accepts the input word this cycle
//            in_data    [WIDTH-1:0]  input word
//            sel        [1:0]        index of the lane being served
//            out_valid  [3:0]        one-hot, bit sel set while a word is held
//            out_ready  [3:0]        per-lane ready
//            out_data   [WIDTH-1:0]  held word, common to all lanes
//            busy       high while a word is held
//            lane_cnt   [4*CNT_W-1:0] per-lane drained-word counters
//                       (present only when DISPATCH_CNT_EN is defined)
// Config   : `define DISPATCH_CNT_EN to add the CNT_W parameter, the lane_cnt
//            port and the per-lane counters.
// Revision : 1.0 - initial release
// ============================================================================
module demux4_rr_dispatch #(
    parameter int WIDTH = 8
`ifdef DISPATCH_CNT_EN
    , parameter int CNT_W = 8
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       lane_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [1:0]       sel,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
`ifdef DISPATCH_CNT_EN
    , output logic [4*CNT_W-1:0] lane_cnt
`endif
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    logic [0:0]       r_state;
    logic [1:0]       r_ptr;
    logic [1:0]       r_sel;
    logic [3:0]       r_out_valid;
    logic [WIDTH-1:0] r_buf;

    logic       w_any_en;
    logic       w_in_ready;
    logic       w_accept;
    logic       w_drain;
    logic [7:0] w_dbl;
    logic [3:0] w_rot;
    logic [1:0] w_off;
    logic [1:0] w_nxt;

    assign w_any_en = |lane_en;

    // Rotate the enable mask so bit k corresponds to lane (ptr+k) mod 4; the
    // lowest set bit of the rotated mask is the distance from ptr to nxt.
    assign w_dbl = {lane_en, lane_en};
    assign w_rot = w_dbl[r_ptr +: 4];

    always_comb begin
        w_off = 2'd0;
        casez (w_rot)
            4'b???1: w_off = 2'd0;
            4'b??10: w_off = 2'd1;
            4'b?100: w_off = 2'd2;
            4'b1000: w_off = 2'd3;
            default: w_off = 2'd0;
        endcase
    end

    assign w_nxt = r_ptr + w_off;

    // Only the served lane's ready matters; a drain frees the buffer in the
    // same cycle so a new word can be taken without a bubble.
    assign w_drain    = (r_state == S_HOLD) & out_ready[r_sel];
    assign w_in_ready = ~rst & w_any_en & ((r_state == S_IDLE) | w_drain);
    assign w_accept   = in_valid & w_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= 2'd0;
            r_sel       <= 2'd0;
            r_out_valid <= 4'd0;
            r_buf       <= '0;
        end else if (w_accept) begin
            // Lane choice is committed here; later lane_en changes do not
            // re-route the held word.
            r_state     <= S_HOLD;
            r_buf       <= in_data;
            r_sel       <= w_nxt;
            r_ptr       <= w_nxt + 2'd1;
            r_out_valid <= 4'b0001 << w_nxt;
        end else if (w_drain) begin
            r_state     <= S_IDLE;
            r_out_valid <= 4'd0;
        end
    end

    assign in_ready  = w_in_ready;
    assign sel       = r_sel;
    assign out_valid = r_out_valid;
    assign out_data  = r_buf;
    assign busy      = (r_state == S_HOLD);

`ifdef DISPATCH_CNT_EN
    logic [CNT_W-1:0] r_cnt [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane_cnt
        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt[gi] <= '0;
            end else if (w_drain && (r_sel == 2'(gi))) begin
                r_cnt[gi] <= r_cnt[gi] + 1'b1;
            end
        end
        assign lane_cnt[gi*CNT_W +: CNT_W] = r_cnt[gi];
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_demux4_rr_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux4_rr_dispatch
// Purpose  : Self-checking bench for demux4_rr_dispatch. A reference model of
//            the round-robin pointer picks the expected lane for every
//            accepted word and pushes {lane, data} to a scoreboard queue; the
//            entry is popped and compared when the DUT drains it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux4_rr_dispatch;

    localparam int WIDTH = 8;

    typedef struct packed {
        logic [1:0]       lane;
        logic [WIDTH-1:0] data;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       lane_en;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       sel;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;
`ifdef DISPATCH_CNT_EN
    logic [31:0]      lane_cnt;
`endif

    demux4_rr_dispatch #(
        .WIDTH(WIDTH)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .lane_en  (lane_en),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .sel      (sel),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy)
`ifdef DISPATCH_CNT_EN
        , .lane_cnt(lane_cnt)
`endif
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fails  = 0;
    exp_t sb[$];
    int   delivered[$];
    logic [1:0] m_ptr;
    int   tally[4];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] model_nxt(input logic [1:0] ptr, input logic [3:0] en);
        logic [1:0] idx;
        model_nxt = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (en[idx]) model_nxt = idx;
        end
    endfunction

    // One clock cycle: drive inputs after the falling edge, check the DUT
    // against the model, update the model, then advance past the rising edge.
    task automatic step(input logic [3:0] en, input logic v, input logic [WIDTH-1:0] d,
                        input logic [3:0] ordy);
        logic       hold;
        logic       exp_rdy;
        logic [3:0] exp_ov;
        logic [1:0] nxt;
        exp_t       e;
        lane_en   = en;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        #1;
        hold    = (sb.size() != 0);
        exp_rdy = (|en) && (!hold || ordy[sb[0].lane]);
        exp_ov  = hold ? (4'b0001 << sb[0].lane) : 4'b0000;
        check_eq("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        check_eq("out_valid", {28'd0, out_valid}, {28'd0, exp_ov});
        check_eq("busy", {31'd0, busy}, {31'd0, hold});
        if (hold) begin
            check_eq("sel", {30'd0, sel}, {30'd0, sb[0].lane});
            check_eq("out_data", {24'd0, out_data}, {24'd0, sb[0].data});
            if (ordy[sb[0].lane]) begin
                e = sb.pop_front();
                delivered.push_back(int'(e.lane));
                tally[e.lane]++;
            end
        end
        if (v && exp_rdy) begin
            nxt     = model_nxt(m_ptr, en);
            e.lane  = nxt;
            e.data  = d;
            sb.push_back(e);
            m_ptr   = nxt + 2'd1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain_all();
        for (int i = 0; i < 4 && sb.size() != 0; i++) step(4'h0, 1'b0, 8'h00, 4'hF);
        check_eq("drain_timeout", sb.size(), 0);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        lane_en   = 4'hF;
        out_ready = 4'h0;
        #1;
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        m_ptr = 2'd0;
        for (int i = 0; i < 4; i++) tally[i] = 0;
        #1;
        check_eq("rst_out_valid", {28'd0, out_valid}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_sel", {30'd0, sel}, 32'd0);
        check_eq("rst_out_data", {24'd0, out_data}, 32'd0);
`ifdef DISPATCH_CNT_EN
        check_eq("rst_lane_cnt", lane_cnt, 32'd0);
`endif
        @(negedge clk);
    endtask

    task automatic check_lanes(input string tag, input int exp[]);
        check_eq({tag, "_count"}, delivered.size(), exp.size());
        for (int i = 0; i < exp.size() && i < delivered.size(); i++)
            check_eq(tag, delivered[i], exp[i]);
    endtask

    initial begin
        int exp_a[];
        rst       = 1'b0;
        lane_en   = 4'h0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 4'h0;
        m_ptr     = 2'd0;
        @(negedge clk);
        do_reset();

        // Full mask, all ready: one word per cycle rotating 0,1,2,3,0.
        delivered.delete();
        step(4'hF, 1'b1, 8'h11, 4'hF);
        step(4'hF, 1'b1, 8'h22, 4'hF);
        step(4'hF, 1'b1, 8'h33, 4'hF);
        step(4'hF, 1'b1, 8'h44, 4'hF);
        step(4'hF, 1'b1, 8'h55, 4'hF);
        drain_all();
        exp_a = '{0, 1, 2, 3, 0};
        check_lanes("rr_full", exp_a);

        // Mask 1010: only lanes 1 and 3 served.
        delivered.delete();
        for (int i = 0; i < 4; i++) step(4'b1010, 1'b1, 8'(8'h60 + i), 4'hF);
        drain_all();
        exp_a = '{1, 3, 1, 3};
        check_lanes("rr_mask", exp_a);

        // Lane 2 stalled five cycles while other lanes are ready, then a
        // drain and an accept land in the same cycle.
        delivered.delete();
        step(4'b0100, 1'b1, 8'hA0, 4'b1011);
        for (int i = 1; i <= 5; i++) step(4'b0100, 1'b1, 8'(8'hA0 + i), 4'b1011);
        step(4'b0100, 1'b1, 8'hB0, 4'b0100);
        drain_all();
        exp_a = '{2, 2};
        check_lanes("stall", exp_a);

        // No lane enabled: never ready.
        for (int i = 0; i < 4; i++) step(4'h0, 1'b1, 8'hC0, 4'hF);
        check_eq("no_lane_sb", sb.size(), 0);

        // Lane 1 disabled while holding: the word still goes out on lane 1.
        delivered.delete();
        step(4'b0010, 1'b1, 8'hD1, 4'h0);
        step(4'b0000, 1'b0, 8'h00, 4'h0);
        step(4'b0000, 1'b0, 8'h00, 4'b1101);
        step(4'b0000, 1'b0, 8'h00, 4'b0010);
        exp_a = '{1};
        check_lanes("en_clr", exp_a);

        // Reset while holding on lane 3 discards the word; next goes to lane 0.
        step(4'b1000, 1'b1, 8'hE3, 4'h0);
        step(4'b1000, 1'b0, 8'h00, 4'h0);
        do_reset();
        delivered.delete();
        step(4'hF, 1'b1, 8'hF0, 4'hF);
        drain_all();
        exp_a = '{0};
        check_lanes("post_rst", exp_a);

`ifdef DISPATCH_CNT_EN
        // 257 words to lane 0 only: an 8-bit counter wraps to 1.
        do_reset();
        for (int i = 0; i < 257; i++) step(4'b0001, 1'b1, 8'(i), 4'hF);
        drain_all();
        #1;
        check_eq("cnt_wrap", {24'd0, lane_cnt[7:0]}, 32'd1);
        for (int i = 0; i < 4; i++)
            check_eq("lane_cnt", {24'd0, lane_cnt[i*8 +: 8]}, 32'(tally[i] % 256));
        @(negedge clk);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
